// File: rtl/id_branch_resolve.sv
// ID-stage branch resolver: operand select, hazard stall FSM,
// BEQ/BNE redirect and saturating event counters.
module id_branch_resolve #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic              id_kill,
    input  logic [PC_W-1:0]   id_pc_plus4,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] rs_rf_data,
    input  logic [DATA_W-1:0] rt_rf_data,
    input  logic [1:0]        forward3,
    input  logic [1:0]        forward4,
    input  logic              ex_mem_read,
    input  logic              mem_mem_read,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              pc_src,
    output logic [PC_W-1:0]   branch_target,
    output logic              if_flush,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        S_IDLE,
        S_STALL
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_rem;
    logic [1:0]        w_rem_nx;
    logic              w_is_br;
    logic [1:0]        w_n3;
    logic [1:0]        w_n4;
    logic [1:0]        w_need;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_take;
    logic              w_stall;
    logic              w_resolve;

    // Cycles a producer still needs before its value reaches ID.
    function automatic logic [1:0] need_f(
        input logic [1:0] sel,
        input logic       exl,
        input logic       meml
    );
        logic [1:0] n;
        n = 2'd0;
        if (sel == 2'b01) n = exl ? 2'd2 : 2'd1;
        else if (sel == 2'b10 && meml) n = 2'd1;
        return n;
    endfunction

    assign w_is_br = id_valid & (id_beq | id_bne) & ~id_kill;
    assign w_n3    = need_f(forward3, ex_mem_read, mem_mem_read);
    assign w_n4    = need_f(forward4, ex_mem_read, mem_mem_read);
    assign w_need  = (w_n3 > w_n4) ? w_n3 : w_n4;

    // Comparison operand muxes driven by the forwarding selects.
    always_comb begin
        w_a = rs_rf_data;
        w_b = rt_rf_data;
        unique case (forward3)
            2'b00: w_a = rs_rf_data;
            2'b01: w_a = ex_result;
            2'b10: w_a = mem_result;
            2'b11: w_a = wb_data;
        endcase
        unique case (forward4)
            2'b00: w_b = rt_rf_data;
            2'b01: w_b = ex_result;
            2'b10: w_b = mem_result;
            2'b11: w_b = wb_data;
        endcase
    end

    assign w_take = (id_beq & (w_a == w_b)) | (id_bne & (w_a != w_b));

    // Stall FSM next-state and resolve decision.
    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_rem;
        w_stall    = 1'b0;
        w_resolve  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_is_br) begin
                    if (w_need != 2'd0) begin
                        w_stall  = 1'b1;
                        w_rem_nx = w_need - 2'd1;
                        if (w_need == 2'd2) w_state_nx = S_STALL;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            S_STALL: begin
                w_stall  = ~id_kill;
                w_rem_nx = r_rem - 2'd1;
                if (r_rem == 2'd1 || id_kill) begin
                    w_state_nx = S_IDLE;
                    w_rem_nx   = 2'd0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_rem_nx   = 2'd0;
            end
        endcase
    end

    assign stall         = w_stall & ~rst;
    assign pc_src        = w_resolve & w_take & ~rst;
    assign if_flush      = pc_src;
    assign branch_target = id_pc_plus4
                         + PC_W'($signed({id_imm, 2'b00}));

    // FSM state and remaining-stall register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_rem   <= w_rem_nx;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_resolve && br_cnt != '1) br_cnt <= br_cnt + 1'b1;
            if (pc_src && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_branch_resolve.sv
// Self-checking bench for id_branch_resolve: directed scenarios
// plus randomized cycles against a behavioural model.
module tb_id_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_beq, id_bne, id_kill;
    logic [31:0] id_pc_plus4, id_imm, rs_rf_data, rt_rf_data;
    logic [1:0]  forward3, forward4;
    logic        ex_mem_read, mem_mem_read;
    logic [31:0] ex_result, mem_result, wb_data;
    logic        stall, pc_src, if_flush;
    logic [31:0] branch_target;
    logic [15:0] br_cnt, taken_cnt, stall_cnt;

    int errs = 0;
    int checks = 0;

    // model state: stall cycles still owed, event totals
    int m_left, m_br, m_tk, m_st;
    // model expectations for the current cycle
    logic        e_stall, e_pc, e_res;
    logic [31:0] e_tgt;
    int          e_n;

    id_branch_resolve dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
        .id_kill(id_kill), .id_pc_plus4(id_pc_plus4), .id_imm(id_imm),
        .rs_rf_data(rs_rf_data), .rt_rf_data(rt_rf_data),
        .forward3(forward3), .forward4(forward4),
        .ex_mem_read(ex_mem_read), .mem_mem_read(mem_mem_read),
        .ex_result(ex_result), .mem_result(mem_result), .wb_data(wb_data),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .if_flush(if_flush), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic int need(input logic [1:0] s);
        if (s == 2'd1) return ex_mem_read ? 2 : 1;
        if (s == 2'd2 && mem_mem_read) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] opnd(input logic [1:0] s,
                                         input logic [31:0] rf);
        case (s)
            2'd0: return rf;
            2'd1: return ex_result;
            2'd2: return mem_result;
            default: return wb_data;
        endcase
    endfunction

    task automatic eval();
        logic [31:0] a, b;
        bit isbr;
        isbr = id_valid && (id_beq || id_bne) && !id_kill;
        e_stall = 0; e_pc = 0; e_res = 0;
        e_n = need(forward3) > need(forward4) ? need(forward3) : need(forward4);
        e_tgt = id_pc_plus4 + id_imm * 4;
        if (rst) begin
        end else if (m_left > 0) begin
            e_stall = !id_kill;
        end else if (isbr) begin
            if (e_n > 0) e_stall = 1;
            else begin
                e_res = 1;
                a = opnd(forward3, rs_rf_data);
                b = opnd(forward4, rt_rf_data);
                e_pc = id_beq ? (a == b) : (a != b);
            end
        end
    endtask

    task automatic adv();
        eval();
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_br = 0; m_tk = 0; m_st = 0;
        end else begin
            if (m_left > 0) m_left = id_kill ? 0 : m_left - 1;
            else if (e_stall) m_left = e_n - 1;
            if (e_res && m_br < 65535) m_br++;
            if (e_pc && m_tk < 65535) m_tk++;
            if (e_stall && m_st < 65535) m_st++;
        end
        @(negedge clk);
    endtask

    task automatic clr_in();
        id_valid = 0; id_beq = 0; id_bne = 0; id_kill = 0;
        id_pc_plus4 = 0; id_imm = 0; rs_rf_data = 0; rt_rf_data = 0;
        forward3 = 0; forward4 = 0; ex_mem_read = 0; mem_mem_read = 0;
        ex_result = 0; mem_result = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        adv();
        rst = 0;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1;
        id_valid = 1; id_beq = 1; forward3 = 2'd1; ex_mem_read = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || pc_src !== 1'b0 || if_flush !== 1'b0) begin
            errs++;
            $display("FAIL reset.outs got=%b%b%b exp=000",
                     stall, pc_src, if_flush);
        end
        adv();
        checks++;
        if (br_cnt !== 0 || taken_cnt !== 0 || stall_cnt !== 0) begin
            errs++;
            $display("FAIL reset.cnt got=%h/%h/%h exp=0/0/0",
                     br_cnt, taken_cnt, stall_cnt);
        end
        rst = 0;
        clr_in();
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errs++;
            $display("FAIL reset.release got=%b exp=0", stall);
        end
        adv();
    endtask

    task automatic test_beq_taken();
        do_reset();
        id_valid = 1; id_beq = 1; rs_rf_data = 5; rt_rf_data = 5;
        id_pc_plus4 = 32'h100; id_imm = 3;
        #1;
        checks++;
        if (pc_src !== 1'b1 || if_flush !== 1'b1 || stall !== 1'b0) begin
            errs++;
            $display("FAIL beq.redirect got=%b%b%b exp=110",
                     pc_src, if_flush, stall);
        end
        checks++;
        if (branch_target !== 32'h10C) begin
            errs++;
            $display("FAIL beq.target got=%h exp=0000010c", branch_target);
        end
        adv();
        clr_in();
        #1;
        checks++;
        if (br_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
            errs++;
            $display("FAIL beq.cnt got=%0d/%0d exp=1/1", br_cnt, taken_cnt);
        end
        id_valid = 1; id_beq = 1; id_imm = 32'hFFFF_FFFF;
        id_pc_plus4 = 32'h0000_0002;
        #1;
        checks++;
        if (branch_target !== 32'hFFFF_FFFE) begin
            errs++;
            $display("FAIL beq.negimm got=%h exp=fffffffe", branch_target);
        end
        adv();
    endtask

    task automatic test_bne_fwd();
        int br0, tk0;
        clr_in();
        br0 = m_br; tk0 = m_tk;
        id_valid = 1; id_bne = 1; forward3 = 2'd2; mem_mem_read = 0;
        mem_result = 7; rt_rf_data = 7; rs_rf_data = 9;
        #1;
        checks++;
        if (stall !== 1'b0 || pc_src !== 1'b0) begin
            errs++;
            $display("FAIL bne.outs got=%b%b exp=00", stall, pc_src);
        end
        adv();
        clr_in();
        #1;
        checks++;
        if (br_cnt !== 16'(br0 + 1) || taken_cnt !== 16'(tk0)) begin
            errs++;
            $display("FAIL bne.cnt got=%0d/%0d exp=%0d/%0d",
                     br_cnt, taken_cnt, br0 + 1, tk0);
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        id_valid = 1; id_beq = 1; forward3 = 2'd1; ex_mem_read = 1;
        rs_rf_data = 1; rt_rf_data = 2;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || pc_src !== 1'b0) begin
                errs++;
                $display("FAIL load.stall%0d got=%b%b exp=10",
                         c, stall, pc_src);
            end
            adv();
        end
        forward3 = 2'd3; forward4 = 2'd3; ex_mem_read = 0;
        wb_data = 32'h55;
        #1;
        checks++;
        if (stall !== 1'b0 || pc_src !== 1'b1) begin
            errs++;
            $display("FAIL load.resolve got=%b%b exp=01", stall, pc_src);
        end
        adv();
        clr_in();
        #1;
        checks++;
        if (stall_cnt !== 16'd2 || br_cnt !== 16'd1) begin
            errs++;
            $display("FAIL load.cnt got=%0d/%0d exp=2/1", stall_cnt, br_cnt);
        end
    endtask

    task automatic test_alu_stall();
        int st0;
        clr_in();
        st0 = m_st;
        id_valid = 1; id_beq = 1; forward4 = 2'd1; ex_mem_read = 0;
        rs_rf_data = 32'h1234; ex_result = 32'h1234; mem_result = 32'h999;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL alu.stall got=%b exp=1", stall);
        end
        adv();
        forward4 = 2'd2;
        #1;
        checks++;
        if (stall !== 1'b0 || pc_src !== 1'b0) begin
            errs++;
            $display("FAIL alu.resolve got=%b%b exp=00", stall, pc_src);
        end
        adv();
        clr_in();
        #1;
        checks++;
        if (stall_cnt !== 16'(st0 + 1)) begin
            errs++;
            $display("FAIL alu.stcnt got=%0d exp=%0d", stall_cnt, st0 + 1);
        end
    endtask

    task automatic test_rst_mid_stall();
        clr_in();
        id_valid = 1; id_beq = 1; forward3 = 2'd1; ex_mem_read = 1;
        adv();
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL rststall.pre got=%b exp=1", stall);
        end
        rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || br_cnt !== 0 || stall_cnt !== 0) begin
            errs++;
            $display("FAIL rststall.async got=%b/%0d/%0d exp=0/0/0",
                     stall, br_cnt, stall_cnt);
        end
        adv();
        rst = 0;
        clr_in();
        #1;
        eval();
        checks++;
        if (stall !== e_stall) begin
            errs++;
            $display("FAIL rststall.after got=%b exp=%b", stall, e_stall);
        end
        adv();
    endtask

    task automatic test_kill();
        int br0;
        clr_in();
        id_valid = 1; id_beq = 1; forward3 = 2'd1; ex_mem_read = 1;
        adv();
        br0 = m_br;
        id_kill = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || pc_src !== 1'b0) begin
            errs++;
            $display("FAIL kill.outs got=%b%b exp=00", stall, pc_src);
        end
        adv();
        clr_in();
        #1;
        checks++;
        if (stall !== 1'b0 || br_cnt !== 16'(br0)) begin
            errs++;
            $display("FAIL kill.idle got=%b/%0d exp=0/%0d",
                     stall, br_cnt, br0);
        end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            id_beq = $urandom_range(0, 1);
            id_bne = !id_beq && ($urandom_range(0, 3) != 0);
            id_kill = ($urandom_range(0, 9) == 0);
            id_pc_plus4 = $urandom;
            id_imm = $urandom;
            rs_rf_data = $urandom_range(0, 3);
            rt_rf_data = $urandom_range(0, 3);
            ex_result = $urandom_range(0, 3);
            mem_result = $urandom_range(0, 3);
            wb_data = $urandom_range(0, 3);
            forward3 = 2'($urandom_range(0, 3));
            forward4 = 2'($urandom_range(0, 3));
            ex_mem_read = $urandom_range(0, 1);
            mem_mem_read = $urandom_range(0, 1);
            #1;
            eval();
            checks++;
            if (stall !== e_stall || pc_src !== e_pc || if_flush !== e_pc)
            begin
                errs++;
                $display("FAIL rand.outs[%0d] got=%b%b%b exp=%b%b%b", i,
                         stall, pc_src, if_flush, e_stall, e_pc, e_pc);
            end
            checks++;
            if (branch_target !== e_tgt) begin
                errs++;
                $display("FAIL rand.target[%0d] got=%h exp=%h",
                         i, branch_target, e_tgt);
            end
            checks++;
            if (br_cnt !== 16'(m_br) || taken_cnt !== 16'(m_tk) ||
                stall_cnt !== 16'(m_st)) begin
                errs++;
                $display("FAIL rand.cnt[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         i, br_cnt, taken_cnt, stall_cnt, m_br, m_tk, m_st);
            end
            adv();
        end
        clr_in();
        adv();
        adv();
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid = 1; id_beq = 1;
        for (int i = 0; i < 65534; i++) adv();
        #1;
        checks++;
        if (br_cnt !== 16'hFFFE || taken_cnt !== 16'hFFFE) begin
            errs++;
            $display("FAIL sat.pre got=%h/%h exp=fffe/fffe",
                     br_cnt, taken_cnt);
        end
        for (int i = 0; i < 3; i++) adv();
        #1;
        checks++;
        if (br_cnt !== 16'hFFFF || taken_cnt !== 16'hFFFF ||
            stall_cnt !== 16'h0) begin
            errs++;
            $display("FAIL sat.hold got=%h/%h/%h exp=ffff/ffff/0000",
                     br_cnt, taken_cnt, stall_cnt);
        end
    endtask

    initial begin
        m_left = 0; m_br = 0; m_tk = 0; m_st = 0;
        clr_in();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_beq_taken();
        test_bne_fwd();
        test_load_stall();
        test_alu_stall();
        test_rst_mid_stall();
        test_kill();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
